reflet_boot_loader: RTL and testbench
=====================================

Name: reflet_boot_loader

Overview:
- Sits upstream of reflet_cpu, between a byte-stream source (UART receiver) and the CPU's memory port.
- Holds the CPU stopped while a length-prefixed program image is streamed in and written to RAM from address 0.
- Then releases the CPU and hands the memory bus to it.
- When the CPU raises quit, takes the bus back and waits for the next image.

Parameters:
- wordsize, 16, CPU word width in bits; must be a multiple of 8; also the address width.
- BPW (localparam), wordsize/8, bytes per word.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  rx_data valid this cycle.
- rx_ready  output  1  loader accepts a byte; transfer occurs when rx_valid && rx_ready.
- cpu_run  output  1  drives the CPU's reset/run input; high lets the CPU execute.
- cpu_quit  input  1  quit flag from the CPU.
- cpu_addr  input  wordsize  CPU address.
- cpu_data_out  input  wordsize  CPU write data.
- cpu_write_en  input  1  CPU write strobe.
- mem_addr  output  wordsize  address to RAM.
- mem_data  output  wordsize  write data to RAM.
- mem_write_en  output  1  RAM write strobe.
- loading  output  1  high in LEN and LOAD states.
- error  output  1  checksum failure; only driven when the optional feature is compiled in, otherwise tied 0.

Behaviour:
- Reset values:
  - state = LEN; cpu_run = 0; rx_ready = 1; error = 0.
  - mem_write_en = 0; mem_addr = 0; mem_data = 0.
  - Byte counter, word counter, length register and assembly register all 0.
- Reset mid-load or mid-run aborts the current image; RAM contents are not cleared.
- LEN state:
  - Accepts BPW bytes, little-endian, forming length L (words).
  - After the last length byte: L == 0 goes to RUN (or CHECK if feature enabled); otherwise goes to LOAD.
- LOAD state:
  - Accepts bytes little-endian into an assembly register.
  - On acceptance of byte BPW-1 of a word: the next cycle drives mem_write_en = 1 for exactly one cycle, with mem_addr = word index and mem_data = assembled word.
  - Word index increments after each write and wraps modulo 2^wordsize.
  - rx_ready stays 1 throughout, so no back-pressure is needed: the write register is independent of byte assembly.
  - After word L-1 is accepted, go to RUN (or CHECK); the final write still issues in the following cycle.
- RUN state:
  - rx_ready = 0.
  - cpu_run = 1 from the first cycle after entering RUN and after the final write has completed. The final write completes in the entry cycle, so cpu_run rises one cycle after the last write strobe.
  - Memory outputs are a combinational mux: mem_addr = cpu_addr, mem_data = cpu_data_out, mem_write_en = cpu_write_en.
  - cpu_quit sampled high: next cycle cpu_run = 0, the bus returns to the loader with mem_write_en = 0, counters clear, state = LEN.
- rx_valid with rx_ready low is ignored; bytes are not buffered.
- cpu_quit outside RUN is ignored.
- Bus ownership: while not in RUN, CPU inputs are ignored and mem_write_en is driven only by the loader.

Optional Feature:
- Macro: REFLET_BOOT_CHECKSUM_EN.
- With the macro:
  - One extra byte follows the payload: the XOR of all payload bytes (length bytes excluded).
  - A CHECK state consumes it.
  - Match goes to RUN.
  - Mismatch goes to ERROR: error = 1, cpu_run = 0, rx_ready = 0, held until reset.
  - L == 0 expects checksum 0x00.
- Without the macro: no CHECK or ERROR states; error is tied 0; LEN or LOAD completion goes straight to RUN.

Decomposition:
- Package reflet_boot_pkg holds:
  - State enum: LEN, LOAD, CHECK, RUN, ERROR.
  - Function computing BPW from wordsize.
- One sub-module is natural: reflet_byte_assembler. It takes bytes with valid and BPW and outputs a word_valid pulse with the little-endian word. It is used for both the length field and the payload.

Test Plan:
- wordsize=8: stream 03,A1,B2,C3.
  - Writes (0,A1), (1,B2), (2,C3), one cycle after each accept.
  - cpu_run rises one cycle after the last write; rx_ready = 0.
- wordsize=16: stream 02,00,34,12,78,56.
  - Writes (0,0x1234), (1,0x5678).
  - No write strobes during the length phase.
- RUN with cpu_write_en=1, cpu_addr=5, cpu_data_out=9: mem bus mirrors the CPU same-cycle; cpu_quit=1 leads next cycle to cpu_run=0, loading=1, state LEN, and a new image loads correctly.
- Length 00 (wordsize=8): cpu_run = 1 without any mem_write_en pulse.
- Reset asserted after 2 of 3 payload bytes: outputs return to reset values next cycle; a fresh image then loads starting at address 0.
- With REFLET_BOOT_CHECKSUM_EN (wordsize=8):
  - Stream 02,0F,F0,FF: RUN.
  - Stream 02,0F,F0,00: error = 1, cpu_run stays 0 until reset.

Source files
------------

// File: rtl/reflet_boot_pkg.sv
// reflet_boot_pkg
// Shared types and helpers for the reflet boot loader.
//   boot_state_t   : loader state encoding (LEN, LOAD, CHECK, RUN, ERROR)
//   bytes_per_word : number of bytes in a CPU word of the given width
package reflet_boot_pkg;

  typedef enum logic [2:0] {
    LEN   = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    RUN   = 3'd3,
    ERROR = 3'd4
  } boot_state_t;

  function automatic int bytes_per_word(input int wordsize);
    return wordsize / 8;
  endfunction

endpackage

// File: rtl/reflet_byte_assembler.sv
// reflet_byte_assembler
// Collects a little-endian stream of bytes into WIDTH-bit words.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   clear       : synchronous restart of word assembly (drops partial word)
//   byte_data   : incoming byte
//   byte_valid  : byte_data is consumed this cycle
//   word_valid  : combinational pulse, high in the cycle the last byte of a
//                 word is consumed
//   word        : assembled word, valid together with word_valid
// The final byte is bypassed straight into word, so a consumer can register
// the complete word on the same edge that consumes its last byte.
module reflet_byte_assembler
  import reflet_boot_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [7:0]       byte_data,
  input  logic             byte_valid,
  output logic             word_valid,
  output logic [WIDTH-1:0] word
);

  localparam int BPW = bytes_per_word(WIDTH);
  localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

  logic [CW-1:0] cnt_reg;
  logic          last_byte;

  assign last_byte  = (cnt_reg == CW'(BPW - 1));
  assign word_valid = byte_valid && last_byte;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_reg <= '0;
    end else if (byte_valid) begin
      cnt_reg <= last_byte ? '0 : cnt_reg + 1'b1;
    end
  end

  generate
    if (BPW == 1) begin : g_single
      assign word = byte_data;
    end else begin : g_multi
      // Holds bytes 0..BPW-2 of the word being assembled.
      logic [WIDTH-9:0] asm_reg;

      always_ff @(posedge clk) begin
        if (reset || clear) begin
          asm_reg <= '0;
        end else if (byte_valid) begin
          for (int i = 0; i < BPW - 1; i++) begin
            if (cnt_reg == CW'(i)) begin
              asm_reg[i*8 +: 8] <= byte_data;
            end
          end
        end
      end

      assign word = {byte_data, asm_reg};
    end
  endgenerate

endmodule

// File: rtl/reflet_boot_loader.sv
// reflet_boot_loader
// Streams a length-prefixed program image from a byte source into RAM
// starting at address 0, then releases the CPU and hands it the memory bus.
// When the CPU raises quit the loader reclaims the bus and waits for the
// next image.
// Optional build macro: REFLET_BOOT_CHECKSUM_EN adds a trailing XOR checksum
// byte (CHECK state) and a sticky ERROR state on mismatch.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   rx_data/rx_valid   : incoming byte stream
//   rx_ready           : loader will take a byte this cycle
//   cpu_run            : high lets the CPU execute
//   cpu_quit           : CPU requests return to the loader
//   cpu_addr/cpu_data_out/cpu_write_en : CPU memory port
//   mem_addr/mem_data/mem_write_en     : RAM port
//   loading            : high while receiving length or payload
//   error              : checksum mismatch (0 unless checksum is built in)
module reflet_boot_loader
  import reflet_boot_pkg::*;
#(
  parameter int wordsize = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic                rx_ready,
  output logic                cpu_run,
  input  logic                cpu_quit,
  input  logic [wordsize-1:0] cpu_addr,
  input  logic [wordsize-1:0] cpu_data_out,
  input  logic                cpu_write_en,
  output logic [wordsize-1:0] mem_addr,
  output logic [wordsize-1:0] mem_data,
  output logic                mem_write_en,
  output logic                loading,
  output logic                error
);

`ifdef REFLET_BOOT_CHECKSUM_EN
  localparam boot_state_t PAYLOAD_DONE = CHECK;
`else
  localparam boot_state_t PAYLOAD_DONE = RUN;
`endif

  boot_state_t         state_reg, state_next;
  logic [wordsize-1:0] len_reg, len_next;
  logic [wordsize-1:0] idx_reg, idx_next;
  logic [wordsize-1:0] maddr_reg, maddr_next;
  logic [wordsize-1:0] mdata_reg, mdata_next;
  logic                mwe_reg, mwe_next;
  logic                run_reg, run_next;
`ifdef REFLET_BOOT_CHECKSUM_EN
  logic [7:0]          csum_reg, csum_next;
`endif

  logic                accept;
  logic                asm_valid;
  logic                quit_event;
  logic                word_valid;
  logic [wordsize-1:0] word;

  assign loading = (state_reg == LEN) || (state_reg == LOAD);
`ifdef REFLET_BOOT_CHECKSUM_EN
  assign rx_ready = loading || (state_reg == CHECK);
  assign error    = (state_reg == ERROR);
`else
  assign rx_ready = loading;
  assign error    = 1'b0;
`endif

  assign accept    = rx_valid && rx_ready;
  assign asm_valid = accept && loading;
  // Quit is only honoured once the CPU is actually running.
  assign quit_event = (state_reg == RUN) && run_reg && cpu_quit;

  reflet_byte_assembler #(
    .WIDTH(wordsize)
  ) u_asm (
    .clk       (clk),
    .reset     (reset),
    .clear     (quit_event),
    .byte_data (rx_data),
    .byte_valid(asm_valid),
    .word_valid(word_valid),
    .word      (word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= LEN;
      len_reg   <= '0;
      idx_reg   <= '0;
      maddr_reg <= '0;
      mdata_reg <= '0;
      mwe_reg   <= 1'b0;
      run_reg   <= 1'b0;
`ifdef REFLET_BOOT_CHECKSUM_EN
      csum_reg  <= '0;
`endif
    end else begin
      state_reg <= state_next;
      len_reg   <= len_next;
      idx_reg   <= idx_next;
      maddr_reg <= maddr_next;
      mdata_reg <= mdata_next;
      mwe_reg   <= mwe_next;
      run_reg   <= run_next;
`ifdef REFLET_BOOT_CHECKSUM_EN
      csum_reg  <= csum_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    len_next   = len_reg;
    idx_next   = idx_reg;
    maddr_next = maddr_reg;
    mdata_next = mdata_reg;
    mwe_next   = 1'b0;
    run_next   = run_reg;
`ifdef REFLET_BOOT_CHECKSUM_EN
    csum_next  = csum_reg;
`endif
    case (state_reg)
      LEN: begin
        if (word_valid) begin
          len_next = word;
          idx_next = '0;
`ifdef REFLET_BOOT_CHECKSUM_EN
          csum_next = '0;
`endif
          state_next = (word == '0) ? PAYLOAD_DONE : LOAD;
        end
      end
      LOAD: begin
`ifdef REFLET_BOOT_CHECKSUM_EN
        if (accept) csum_next = csum_reg ^ rx_data;
`endif
        if (word_valid) begin
          // The write register is loaded on the edge that takes the last
          // byte, so the strobe appears in the following cycle.
          mwe_next   = 1'b1;
          maddr_next = idx_reg;
          mdata_next = word;
          idx_next   = idx_reg + 1'b1;
          if (idx_reg == len_reg - 1'b1) state_next = PAYLOAD_DONE;
        end
      end
`ifdef REFLET_BOOT_CHECKSUM_EN
      CHECK: begin
        if (accept) state_next = (rx_data == csum_reg) ? RUN : ERROR;
      end
      ERROR: begin
        state_next = ERROR;
      end
`endif
      RUN: begin
        // The entry cycle carries the final loader write; the CPU is
        // released from the cycle after.
        run_next = 1'b1;
        if (quit_event) begin
          run_next   = 1'b0;
          state_next = LEN;
          len_next   = '0;
          idx_next   = '0;
          maddr_next = '0;
          mdata_next = '0;
        end
      end
      default: begin
        state_next = LEN;
      end
    endcase
  end

  // Bus belongs to the CPU exactly while it is running.
  always_comb begin
    if (run_reg) begin
      mem_addr     = cpu_addr;
      mem_data     = cpu_data_out;
      mem_write_en = cpu_write_en;
    end else begin
      mem_addr     = maddr_reg;
      mem_data     = mdata_reg;
      mem_write_en = mwe_reg;
    end
  end

  assign cpu_run = run_reg;

endmodule

// File: tb/tb_reflet_boot_loader.sv
// Testbench for reflet_boot_loader: one 8-bit and one 16-bit instance.
// Expected RAM writes are queued when an image is issued; a monitor pops
// and compares whenever a DUT raises mem_write_en.
module tb_reflet_boot_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // 8-bit instance
  logic [7:0] a_rx_data, a_cpu_addr, a_cpu_dout, a_mem_addr, a_mem_data;
  logic a_rx_valid, a_rx_ready, a_cpu_run, a_cpu_quit, a_cpu_we;
  logic a_mem_we, a_loading, a_error;
  // 16-bit instance
  logic [7:0]  b_rx_data;
  logic [15:0] b_cpu_addr, b_cpu_dout, b_mem_addr, b_mem_data;
  logic b_rx_valid, b_rx_ready, b_cpu_run, b_cpu_quit, b_cpu_we;
  logic b_mem_we, b_loading, b_error;

  reflet_boot_loader #(.wordsize(8)) dut8 (
    .clk(clk), .reset(reset),
    .rx_data(a_rx_data), .rx_valid(a_rx_valid), .rx_ready(a_rx_ready),
    .cpu_run(a_cpu_run), .cpu_quit(a_cpu_quit),
    .cpu_addr(a_cpu_addr), .cpu_data_out(a_cpu_dout), .cpu_write_en(a_cpu_we),
    .mem_addr(a_mem_addr), .mem_data(a_mem_data), .mem_write_en(a_mem_we),
    .loading(a_loading), .error(a_error)
  );

  reflet_boot_loader #(.wordsize(16)) dut16 (
    .clk(clk), .reset(reset),
    .rx_data(b_rx_data), .rx_valid(b_rx_valid), .rx_ready(b_rx_ready),
    .cpu_run(b_cpu_run), .cpu_quit(b_cpu_quit),
    .cpu_addr(b_cpu_addr), .cpu_data_out(b_cpu_dout), .cpu_write_en(b_cpu_we),
    .mem_addr(b_mem_addr), .mem_data(b_mem_data), .mem_write_en(b_mem_we),
    .loading(b_loading), .error(b_error)
  );

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t q_a[$];
  wr_t q_b[$];
  logic [7:0] img[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] g_we(input bit sel);
    return sel ? 16'(b_mem_we) : 16'(a_mem_we);
  endfunction
  function automatic logic [15:0] g_run(input bit sel);
    return sel ? 16'(b_cpu_run) : 16'(a_cpu_run);
  endfunction
  function automatic logic [15:0] g_ready(input bit sel);
    return sel ? 16'(b_rx_ready) : 16'(a_rx_ready);
  endfunction
  function automatic logic [15:0] g_loading(input bit sel);
    return sel ? 16'(b_loading) : 16'(a_loading);
  endfunction
  function automatic logic [15:0] g_error(input bit sel);
    return sel ? 16'(b_error) : 16'(a_error);
  endfunction
  function automatic logic [15:0] g_addr(input bit sel);
    return sel ? b_mem_addr : 16'(a_mem_addr);
  endfunction
  function automatic logic [15:0] g_data(input bit sel);
    return sel ? b_mem_data : 16'(a_mem_data);
  endfunction

  task automatic expect_write(input bit sel, input logic [15:0] addr, input logic [15:0] data);
    wr_t e;
    e.addr = addr;
    e.data = data;
    if (sel) q_b.push_back(e);
    else     q_a.push_back(e);
  endtask

  // Write monitor: every strobe must match the next queued expectation.
  always @(negedge clk) begin
    wr_t e;
    if (a_mem_we === 1'b1) begin
      if (q_a.size() == 0) check("dut8_unexpected_write", 32'(q_a.size()), 1);
      else begin
        e = q_a.pop_front();
        $display("mon dut8 write addr=%02h data=%02h", a_mem_addr, a_mem_data);
        check("dut8_write_addr", 32'(a_mem_addr), 32'(e.addr));
        check("dut8_write_data", 32'(a_mem_data), 32'(e.data));
      end
    end
    if (b_mem_we === 1'b1) begin
      if (q_b.size() == 0) check("dut16_unexpected_write", 32'(q_b.size()), 1);
      else begin
        e = q_b.pop_front();
        $display("mon dut16 write addr=%04h data=%04h", b_mem_addr, b_mem_data);
        check("dut16_write_addr", 32'(b_mem_addr), 32'(e.addr));
        check("dut16_write_data", 32'(b_mem_data), 32'(e.data));
      end
    end
  end

  task automatic send_byte(input bit sel, input logic [7:0] b);
    if (sel) begin b_rx_data = b; b_rx_valid = 1'b1; end
    else     begin a_rx_data = b; a_rx_valid = 1'b1; end
    @(posedge clk); #1;
    a_rx_valid = 1'b0;
    b_rx_valid = 1'b0;
    $display("tx dut%0d byte %02h", sel ? 16 : 8, b);
  endtask

  // Sends img; with the checksum build the XOR of payload bytes follows.
  task automatic load_image(input bit sel);
    int bpw;
    logic [7:0] x;
    bpw = sel ? 2 : 1;
    x = 8'h00;
    for (int i = 0; i < img.size(); i++) begin
      send_byte(sel, img[i]);
      if (i >= bpw) x = x ^ img[i];
    end
`ifdef REFLET_BOOT_CHECKSUM_EN
    send_byte(sel, x);
`endif
  endtask

  // Called one step after the last byte was taken.
  task automatic run_entry(input bit sel, input bit had_write);
    logic exp_we;
    exp_we = had_write;
`ifdef REFLET_BOOT_CHECKSUM_EN
    exp_we = 1'b0;
`endif
    check("entry_write_strobe", 32'(g_we(sel)), 32'(exp_we));
    check("entry_cpu_run_low", 32'(g_run(sel)), 0);
    check("entry_rx_ready_low", 32'(g_ready(sel)), 0);
    @(posedge clk); #1;
    check("run_cpu_run_high", 32'(g_run(sel)), 1);
    check("run_no_strobe", 32'(g_we(sel)), 0);
    check("run_loading_low", 32'(g_loading(sel)), 0);
    check("run_rx_ready_low", 32'(g_ready(sel)), 0);
    $display("run dut%0d cpu_run=%0d", sel ? 16 : 8, g_run(sel));
  endtask

  task automatic quit_cpu(input bit sel);
    if (sel) b_cpu_quit = 1'b1; else a_cpu_quit = 1'b1;
    @(posedge clk); #1;
    a_cpu_quit = 1'b0;
    b_cpu_quit = 1'b0;
    check("quit_cpu_run_low", 32'(g_run(sel)), 0);
    check("quit_loading", 32'(g_loading(sel)), 1);
    check("quit_rx_ready", 32'(g_ready(sel)), 1);
    check("quit_no_strobe", 32'(g_we(sel)), 0);
    $display("quit dut%0d loading=%0d", sel ? 16 : 8, g_loading(sel));
  endtask

  task automatic check_reset(input bit sel);
    check("rst_rx_ready", 32'(g_ready(sel)), 1);
    check("rst_cpu_run", 32'(g_run(sel)), 0);
    check("rst_write_en", 32'(g_we(sel)), 0);
    check("rst_addr", 32'(g_addr(sel)), 0);
    check("rst_data", 32'(g_data(sel)), 0);
    check("rst_loading", 32'(g_loading(sel)), 1);
    check("rst_error", 32'(g_error(sel)), 0);
    $display("reset check dut%0d", sel ? 16 : 8);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    a_rx_data = '0; a_rx_valid = 0; a_cpu_quit = 0; a_cpu_addr = '0; a_cpu_dout = '0; a_cpu_we = 0;
    b_rx_data = '0; b_rx_valid = 0; b_cpu_quit = 0; b_cpu_addr = '0; b_cpu_dout = '0; b_cpu_we = 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset(0);
    check_reset(1);
    reset = 1'b0;

    // 8-bit image of three words
    expect_write(0, 16'h0, 16'hA1);
    expect_write(0, 16'h1, 16'hB2);
    expect_write(0, 16'h2, 16'hC3);
    img = '{8'h03, 8'hA1, 8'hB2, 8'hC3};
    load_image(0);
    run_entry(0, 1'b1);

    // CPU owns the bus; then quits while still strobing
    expect_write(0, 16'h5, 16'h9);
    a_cpu_we = 1'b1; a_cpu_addr = 8'h05; a_cpu_dout = 8'h09; a_cpu_quit = 1'b1;
    #1;
    check("mux_addr", 32'(a_mem_addr), 32'h5);
    check("mux_data", 32'(a_mem_data), 32'h9);
    check("mux_write_en", 32'(a_mem_we), 1);
    @(posedge clk); #1;
    a_cpu_quit = 1'b0;
    check("quit_run_low", 32'(a_cpu_run), 0);
    check("quit_loading_high", 32'(a_loading), 1);
    check("quit_cpu_we_ignored", 32'(a_mem_we), 0);
    $display("mux/quit dut8 done");
    a_cpu_we = 1'b0; a_cpu_addr = '0; a_cpu_dout = '0;

    // new image after quit
    expect_write(0, 16'h0, 16'h5A);
    expect_write(0, 16'h1, 16'hA5);
    img = '{8'h02, 8'h5A, 8'hA5};
    load_image(0);
    run_entry(0, 1'b1);
    quit_cpu(0);

    // zero-length image
    img = '{8'h00};
    load_image(0);
    run_entry(0, 1'b0);
    quit_cpu(0);

    // reset after two of three payload bytes
    expect_write(0, 16'h0, 16'h11);
    expect_write(0, 16'h1, 16'h22);
    send_byte(0, 8'h03);
    send_byte(0, 8'h11);
    send_byte(0, 8'h22);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_reset(0);
    check_reset(1);
    expect_write(0, 16'h0, 16'h77);
    img = '{8'h01, 8'h77};
    load_image(0);
    run_entry(0, 1'b1);
    quit_cpu(0);

    // 16-bit image
    expect_write(1, 16'h0, 16'h1234);
    expect_write(1, 16'h1, 16'h5678);
    img = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56};
    load_image(1);
    run_entry(1, 1'b1);
    quit_cpu(1);

`ifdef REFLET_BOOT_CHECKSUM_EN
    // good checksum (0F ^ F0 = FF)
    expect_write(0, 16'h0, 16'h0F);
    expect_write(0, 16'h1, 16'hF0);
    img = '{8'h02, 8'h0F, 8'hF0};
    load_image(0);
    run_entry(0, 1'b0);
    quit_cpu(0);

    // bad checksum
    expect_write(0, 16'h0, 16'h0F);
    expect_write(0, 16'h1, 16'hF0);
    send_byte(0, 8'h02);
    send_byte(0, 8'h0F);
    send_byte(0, 8'hF0);
    send_byte(0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      check("csum_error_set", 32'(a_error), 1);
      check("csum_cpu_run_low", 32'(a_cpu_run), 0);
      check("csum_rx_ready_low", 32'(a_rx_ready), 0);
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_reset(0);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("dut8_writes_drained", 32'(q_a.size()), 0);
    check("dut16_writes_drained", 32'(q_b.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
